vram_plane_ctrl: RTL and testbench

//  N-plane bitmap VRAM controller between the Z80 bus decode and the VDP.

---
 rtl/vram_pkg.sv | 28 ++
 rtl/vram_plane_ctrl_if.sv | 25 ++
 rtl/vram_plane_dpram.sv | 37 +++
 rtl/vram_plane_ctrl.sv | 158 +++++++++++++++
 tb/tb_vram_plane_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared types and helpers for the bitplane VRAM controller: clear FSM states,
// default geometry and read-bank decode.
package vram_pkg;

  localparam int PLANES_DEF = 6;
  localparam int AW_DEF     = 13;
  localparam int DW_DEF     = 8;
  localparam int BANK_W_DEF = 8;
  localparam int MAX_PLANES = 8;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_e;

  // Bank value k in 1..planes selects plane k-1; anything else selects nothing.
  function automatic logic [MAX_PLANES-1:0] bank_decode(input int unsigned k,
                                                        input int unsigned planes);
    logic [MAX_PLANES-1:0] sel;
    sel = '0;
    for (int i = 0; i < MAX_PLANES; i++) begin
      sel[i] = (k == unsigned'(i + 1)) && (unsigned'(i) < planes);
    end
    return sel;
  endfunction

endpackage

// File: rtl/vram_plane_ctrl_if.sv
// Z80-side VRAM window bus: plane access plus read-bank / write-mask register loads.
interface vram_plane_ctrl_if #(
  parameter int AW     = 13,
  parameter int DW     = 8,
  parameter int BANK_W = 8
);
  logic              cpu_cs;
  logic              cpu_wr;
  logic [AW-1:0]     cpu_addr;
  logic [DW-1:0]     cpu_din;
  logic [DW-1:0]     cpu_dout;
  logic              rdb_we;
  logic              wrm_we;
  logic [BANK_W-1:0] bank_din;

  modport master (
    output cpu_cs, cpu_wr, cpu_addr, cpu_din, rdb_we, wrm_we, bank_din,
    input  cpu_dout
  );

  modport slave (
    input  cpu_cs, cpu_wr, cpu_addr, cpu_din, rdb_we, wrm_we, bank_din,
    output cpu_dout
  );
endinterface

// File: rtl/vram_plane_dpram.sv
// One bitplane: shared CPU/clear read-write port and an independent video read
// port, both with registered read data.
module vram_plane_dpram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] cpu_rd_q;
  logic [DW-1:0] vid_q;

  // Read data only advances on a read so the CPU sees it held until the next one.
  always_ff @(posedge clk) begin
    if (cpu_we) mem[cpu_addr] <= cpu_wdata;
    if (cpu_re) cpu_rd_q <= mem[cpu_addr];
  end

  // Video port sees pre-write contents when colliding with a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) vid_q <= '0;
    else       vid_q <= mem[vid_addr];
  end

  assign cpu_rdata = cpu_rd_q;
  assign vid_rdata = vid_q;

endmodule

// File: rtl/vram_plane_ctrl.sv
// N-plane bitmap VRAM controller with read-bank select, write-plane mask and a
// hardware clear engine. Define VRAM_CLEAR_FILL_EN to add the clr_fill port.
module vram_plane_ctrl
  import vram_pkg::*;
#(
  parameter int PLANES = PLANES_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int BANK_W = BANK_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  vram_plane_ctrl_if.slave     bus,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic                 clr_done,
  input  logic [AW-1:0]        vid_addr,
  output logic [PLANES*DW-1:0] vid_data
`ifdef VRAM_CLEAR_FILL_EN
  ,
  input  logic [DW-1:0]        clr_fill
`endif
);

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};

  clr_state_e        state_q, state_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
  logic [PLANES-1:0] wr_mask_q, wr_mask_d;
  logic [PLANES-1:0] rd_sel_q, rd_sel_d;
  logic [DW-1:0]     fill;

  logic [MAX_PLANES-1:0] sel_full;
  logic                  rd_hit;
  logic [PLANES-1:0]     rd_sel;
  logic                  busy;
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [AW-1:0]         port_addr;
  logic [DW-1:0]         port_wdata;
  logic [PLANES-1:0]     port_we;
  logic [PLANES-1:0]     port_re;
  logic [DW-1:0]         plane_rd [PLANES];
  logic [DW-1:0]         dout;

`ifdef VRAM_CLEAR_FILL_EN
  logic [DW-1:0] fill_q, fill_d;

  // Fill value is captured once so a changing clr_fill cannot corrupt an active clear.
  always_comb begin
    fill_d = fill_q;
    if (state_q == IDLE && clr_start) fill_d = clr_fill;
  end

  always_ff @(posedge clk) begin
    fill_q <= fill_d;
  end

  assign fill = fill_q;
`else
  assign fill = '0;
`endif

  // ---- control registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_bank_q <= '0;
      wr_mask_q <= '0;
      rd_sel_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_bank_q <= rd_bank_d;
      wr_mask_q <= wr_mask_d;
      rd_sel_q  <= rd_sel_d;
    end
  end

  // ---- clear FSM next state ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_busy = busy;
  assign clr_done = (state_q == DONE);

  // ---- register loads, CPU decode and write-port mux ----
  always_comb begin
    rd_bank_d = bus.rdb_we ? bus.bank_din : rd_bank_q;
    wr_mask_d = bus.wrm_we ? bus.bank_din[PLANES-1:0] : wr_mask_q;

    sel_full = bank_decode(32'(rd_bank_q), PLANES);
    rd_hit   = |sel_full;
    rd_sel   = rd_hit ? sel_full[PLANES-1:0] : '0;

    cpu_rd = bus.cpu_cs & ~bus.cpu_wr & ~busy;
    cpu_wr = bus.cpu_cs &  bus.cpu_wr & ~busy;

    // A read during a clear latches an empty select so it returns zero.
    rd_sel_d = rd_sel_q;
    if (bus.cpu_cs && !bus.cpu_wr) rd_sel_d = busy ? '0 : rd_sel;

    port_addr  = busy ? cnt_q[AW-1:0] : bus.cpu_addr;
    port_wdata = busy ? fill : bus.cpu_din;
    for (int i = 0; i < PLANES; i++) begin
      port_we[i] = busy | (cpu_wr & wr_mask_q[i]);
      port_re[i] = cpu_rd & rd_sel[i];
    end
  end

  for (genvar i = 0; i < PLANES; i++) begin : g_plane
    vram_plane_dpram #(
      .AW (AW),
      .DW (DW)
    ) u_plane (
      .clk       (clk),
      .reset     (reset),
      .cpu_we    (port_we[i]),
      .cpu_re    (port_re[i]),
      .cpu_addr  (port_addr),
      .cpu_wdata (port_wdata),
      .cpu_rdata (plane_rd[i]),
      .vid_addr  (vid_addr),
      .vid_rdata (vid_data[i*DW +: DW])
    );
  end

  // ---- CPU read-data select ----
  always_comb begin
    dout = '0;
    for (int i = 0; i < PLANES; i++) begin
      if (rd_sel_q[i]) dout = dout | plane_rd[i];
    end
  end

  assign bus.cpu_dout = dout;

endmodule

// File: tb/tb_vram_plane_ctrl.sv
// Self-checking bench for vram_plane_ctrl: timeline-based reference model plus
// directed vectors with literal expectations.
module tb_vram_plane_ctrl;

  localparam int PLANES = 6;
  localparam int AW     = 13;
  localparam int DW     = 8;
  localparam int BANK_W = 8;
  localparam int DEPTH  = 1 << AW;

`ifdef VRAM_CLEAR_FILL_EN
  localparam logic [7:0] FILL = 8'h55;
  logic [7:0] clr_fill = 8'h55;
`else
  localparam logic [7:0] FILL = 8'h00;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 clr_start = 1'b0;
  logic                 clr_busy;
  logic                 clr_done;
  logic [AW-1:0]        vid_addr = '0;
  logic [PLANES*DW-1:0] vid_data;

  always #5 clk = ~clk;

  vram_plane_ctrl_if #(.AW(AW), .DW(DW), .BANK_W(BANK_W)) bus ();

  vram_plane_ctrl #(
    .PLANES (PLANES),
    .AW     (AW),
    .DW     (DW),
    .BANK_W (BANK_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data)
`ifdef VRAM_CLEAR_FILL_EN
    ,
    .clr_fill  (clr_fill)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mem [PLANES][DEPTH];
  bit         kn  [PLANES][DEPTH];
  logic [7:0] rdb_m, wrm_m;
  logic [7:0] exp_dout;
  bit         exp_dout_kn = 0;
  logic [7:0] exp_vid [PLANES];
  bit         exp_vid_kn [PLANES];
  bit         exp_busy = 0, exp_done = 0;
  bit         chk_en = 0;
  longint     cyc = 0;
  bit         clr_act = 0;
  longint     clr_t = 0;
  logic [7:0] fill_m = 8'h00;
  int         done_cnt = 0;

  always @(posedge clk) begin : model
    bit busy_now, start_ok;
    int a;
    busy_now = clr_act && (cyc > clr_t) && (cyc <= clr_t + DEPTH);
    a = int'(cyc - clr_t - 1);
    if (reset) begin
      if (busy_now) for (int p = 0; p < PLANES; p++) kn[p][a] = 0;
      rdb_m = 8'h00;
      wrm_m = 8'h00;
      exp_dout = 8'h00;
      exp_dout_kn = 1;
      for (int p = 0; p < PLANES; p++) begin
        exp_vid[p] = 8'h00;
        exp_vid_kn[p] = 1;
      end
      clr_act = 0;
      chk_en = 1;
    end else begin
      for (int p = 0; p < PLANES; p++) begin
        exp_vid[p]    = mem[p][vid_addr];
        exp_vid_kn[p] = kn[p][vid_addr];
      end
      if (bus.cpu_cs && !bus.cpu_wr) begin
        if (busy_now || rdb_m < 1 || rdb_m > PLANES) begin
          exp_dout = 8'h00;
          exp_dout_kn = 1;
        end else begin
          exp_dout    = mem[rdb_m-1][bus.cpu_addr];
          exp_dout_kn = kn[rdb_m-1][bus.cpu_addr];
        end
      end
      if (busy_now) begin
        for (int p = 0; p < PLANES; p++) begin
          mem[p][a] = fill_m;
          kn[p][a]  = 1;
        end
      end else if (bus.cpu_cs && bus.cpu_wr) begin
        for (int p = 0; p < PLANES; p++) begin
          if (wrm_m[p]) begin
            mem[p][bus.cpu_addr] = bus.cpu_din;
            kn[p][bus.cpu_addr]  = 1;
          end
        end
      end
      if (bus.rdb_we) rdb_m = bus.bank_din;
      if (bus.wrm_we) wrm_m = bus.bank_din;
      start_ok = !clr_act;
      if (clr_act && cyc == clr_t + DEPTH + 1) clr_act = 0;
      if (start_ok && clr_start) begin
        clr_act = 1;
        clr_t   = cyc;
`ifdef VRAM_CLEAR_FILL_EN
        fill_m  = clr_fill;
`else
        fill_m  = 8'h00;
`endif
      end
    end
    exp_busy = clr_act && (cyc + 1 > clr_t) && (cyc + 1 <= clr_t + DEPTH);
    exp_done = clr_act && (cyc + 1 == clr_t + DEPTH + 1);
    cyc++;
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("clr_busy", {63'd0, clr_busy}, {63'd0, exp_busy});
      check("clr_done", {63'd0, clr_done}, {63'd0, exp_done});
      if (exp_dout_kn) check("cpu_dout", {56'd0, bus.cpu_dout}, {56'd0, exp_dout});
      for (int p = 0; p < PLANES; p++) begin
        if (exp_vid_kn[p])
          check($sformatf("vid_p%0d", p), {56'd0, vid_data[p*8 +: 8]}, {56'd0, exp_vid[p]});
      end
      if (clr_done) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_wrm(input logic [7:0] v);
    bus.wrm_we = 1'b1; bus.bank_din = v; step(); bus.wrm_we = 1'b0;
  endtask

  task automatic set_rdb(input logic [7:0] v);
    bus.rdb_we = 1'b1; bus.bank_din = v; step(); bus.rdb_we = 1'b0;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
    bus.cpu_cs = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = a; bus.cpu_din = d;
    step();
    bus.cpu_cs = 1'b0; bus.cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, output logic [7:0] d);
    bus.cpu_cs = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = a;
    step();
    bus.cpu_cs = 1'b0;
    d = bus.cpu_dout;
  endtask

  task automatic start_clear();
    clr_start = 1'b1;
`ifdef VRAM_CLEAR_FILL_EN
    clr_fill = FILL;
`endif
    step();
    clr_start = 1'b0;
`ifdef VRAM_CLEAR_FILL_EN
    clr_fill = 8'h12;
`endif
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (clr_busy === 1'b1 && n < DEPTH + 50) begin
      step();
      n++;
    end
    check(name, {63'd0, clr_busy}, 64'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin : stim
    logic [7:0] d;
    int dc0;
    bus.cpu_cs = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.rdb_we = 1'b0; bus.wrm_we = 1'b0; bus.bank_din = '0;

    reset = 1'b1; step(2); reset = 1'b0; step();
    check("rst_busy", {63'd0, clr_busy}, 64'd0);
    check("rst_done", {63'd0, clr_done}, 64'd0);
    check("rst_dout", {56'd0, bus.cpu_dout}, 64'd0);
    check("rst_vid",  {16'd0, vid_data}, 64'd0);

    set_wrm(8'h3F); cpu_write(13'h0010, 8'h00); cpu_write(13'h0005, 8'h00);

    // 1: mask 0b000101
    set_wrm(8'b0000_0101); cpu_write(13'h0010, 8'hA5);
    set_rdb(8'd1); cpu_read(13'h0010, d); check("t1_rdb1", {56'd0, d}, 64'hA5);
    set_rdb(8'd2); cpu_read(13'h0010, d); check("t1_rdb2", {56'd0, d}, 64'h00);
    set_rdb(8'd3); cpu_read(13'h0010, d); check("t1_rdb3", {56'd0, d}, 64'hA5);

    // 2: out-of-range banks and out-of-range mask bits
    set_rdb(8'd0); cpu_read(13'h0010, d); check("t2_rdb0", {56'd0, d}, 64'h00);
    set_rdb(8'd7); cpu_read(13'h0010, d); check("t2_rdb7", {56'd0, d}, 64'h00);
    set_wrm(8'hC0); cpu_write(13'h0010, 8'h77);
    set_rdb(8'd1); cpu_read(13'h0010, d); check("t2_keep1", {56'd0, d}, 64'hA5);
    set_rdb(8'd2); cpu_read(13'h0010, d); check("t2_keep2", {56'd0, d}, 64'h00);

    // 3: same-cycle mask load uses the old mask
    set_wrm(8'h01); cpu_write(13'h0005, 8'h11); set_wrm(8'h02);
    bus.wrm_we = 1'b1; bus.bank_din = 8'h01;
    bus.cpu_cs = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 13'h0005; bus.cpu_din = 8'h3C;
    step();
    bus.wrm_we = 1'b0; bus.cpu_cs = 1'b0; bus.cpu_wr = 1'b0;
    set_rdb(8'd2); cpu_read(13'h0005, d); check("t3_p1", {56'd0, d}, 64'h3C);
    set_rdb(8'd1); cpu_read(13'h0005, d); check("t3_p0", {56'd0, d}, 64'h11);
    cpu_write(13'h0005, 8'h22);
    vid_addr = 13'h0005; step();
    check("t3_vid", {48'd0, vid_data[15:0]}, 64'h3C22);

    // 4: full clear timing and content
    set_wrm(8'h3F);
    cpu_write(13'h0000, 8'hEE); cpu_write(13'h0010, 8'hEE); cpu_write(13'h1FFF, 8'hEE);
    start_clear();
    check("t4_busy_first", {62'd0, clr_busy, clr_done}, 64'd2);
    step(DEPTH - 1);
    check("t4_busy_last", {62'd0, clr_busy, clr_done}, 64'd2);
    step();
    check("t4_done", {62'd0, clr_busy, clr_done}, 64'd1);
    step();
    check("t4_after", {62'd0, clr_busy, clr_done}, 64'd0);
    for (int a = 0; a < DEPTH; a++) begin
      vid_addr = AW'(a);
      step();
    end
    vid_addr = 13'h1FFF; step();
    check("t4_vid_last", {16'd0, vid_data}, {16'd0, {PLANES{FILL}}});
    set_rdb(8'd1); cpu_read(13'h0010, d); check("t4_cpu", {56'd0, d}, {56'd0, FILL});

    // 5: writes, reads and restarts during busy are ignored
    cpu_write(13'd5000, 8'h99);
    dc0 = done_cnt;
    start_clear();
    step(10);
    cpu_write(13'd5000, 8'hFF);
    cpu_read(13'd5000, d); check("t5_busy_read", {56'd0, d}, 64'h00);
    clr_start = 1'b1; step(); clr_start = 1'b0;
    wait_idle("t5_timeout");
    step(3);
    check("t5_one_done", 64'(done_cnt - dc0), 64'd1);
    vid_addr = 13'd5000; step();
    check("t5_vid", {56'd0, vid_data[7:0]}, {56'd0, FILL});
    cpu_read(13'd5000, d); check("t5_cpu", {56'd0, d}, {56'd0, FILL});

    // 6: reset in the middle of a clear, then restart
    cpu_write(13'd50, 8'hAB); cpu_write(13'd8000, 8'hAB);
    set_rdb(8'd3);
    start_clear();
    step(99);
    dc0 = done_cnt;
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_busy_off", {63'd0, clr_busy}, 64'd0);
    step(20);
    check("t6_no_done", 64'(done_cnt - dc0), 64'd0);
    cpu_read(13'd8000, d); check("t6_rdb_reset", {56'd0, d}, 64'h00);
    set_rdb(8'd1);
    cpu_read(13'd8000, d); check("t6_untouched", {56'd0, d}, 64'hAB);
    cpu_read(13'd50, d);   check("t6_cleared", {56'd0, d}, {56'd0, FILL});
    set_wrm(8'h3F); cpu_write(13'd0, 8'hAB); cpu_write(13'd1, 8'hAB);
    dc0 = done_cnt;
    start_clear();
    step(3);
    vid_addr = 13'd0; step();
    check("t6_restart_a0", {56'd0, vid_data[7:0]}, {56'd0, FILL});
    wait_idle("t6_timeout");
    step(3);
    check("t6_one_done", 64'(done_cnt - dc0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
